// File: rtl/ptos_pkg.sv
// ---------------------------------------------------------------------------
// ptos_pkg
// Shared definitions for the parallel-to-serial byte scheduler.
// Contents:
//   COM            - comma/idle symbol the serializer sends when no payload
//   state_t        - scheduler state encoding (TRAIN, IDLE, BURST)
//   DEF_*          - default values of the scheduler parameters
//   wrap_inc()     - requester index increment with wrap to 0
// ---------------------------------------------------------------------------
package ptos_pkg;

  localparam logic [7:0] COM = 8'hBC;

  localparam int DEF_NREQ      = 4;
  localparam int DEF_MAX_BURST = 4;
  localparam int DEF_TRAIN_LEN = 4;

  typedef enum logic [1:0] {
    ST_TRAIN = 2'd0,
    ST_IDLE  = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  // Next requester index after idx, wrapping from n-1 back to 0.
  function automatic logic [1:0] wrap_inc(input logic [1:0] idx, input int n);
    if (int'(idx) >= n - 1) begin
      return 2'd0;
    end
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/ptos_sched_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin selector. Searches the request vector
// starting at index ptr and wrapping, and returns the first set request.
// Ports:
//   req  [NREQ-1:0] in   request vector
//   ptr  [1:0]      in   index with highest priority this cycle
//   gnt  [NREQ-1:0] out  one-hot grant (all zero when no request)
//   idx  [1:0]      out  index of the granted request (0 when none)
//   any             out  at least one request is set
// ---------------------------------------------------------------------------
module rr_arbiter
  import ptos_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      idx,
  output logic            any
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Walk the requesters in priority order ptr, ptr+1, ... and keep the
  // first hit; later hits are ignored once any is set.
  always_comb begin
    int pos;
    logic [IW-1:0] pos_i;
    gnt   = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    pos_i = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NREQ) begin
        pos = pos - NREQ;
      end
      pos_i = IW'(pos);
      if (!any && req[pos_i]) begin
        any        = 1'b1;
        gnt[pos_i] = 1'b1;
        idx        = 2'(pos);
      end
    end
  end

endmodule

// File: rtl/ptos_sched.sv
// ---------------------------------------------------------------------------
// ptos_sched
// Schedules bytes from NREQ requesters onto a single parallel-to-serial
// serializer. After reset release or enable rise the link trains for
// TRAIN_LEN COM cycles, then grants requesters round-robin in bursts of up
// to MAX_BURST bytes with a COM cycle between bursts.
// Parameters:
//   NREQ (<=4), MAX_BURST, TRAIN_LEN
// Ports:
//   clk                  in   byte-rate clock, rising edge
//   reset                in   asynchronous, active-low reset
//   enable               in   run enable; low drops back to training
//   req_data [8*NREQ-1:0] in  byte of requester i in bits [8i+7:8i]
//   req_valid [NREQ-1:0] in   requester i holds a byte
//   req_ready [NREQ-1:0] out  byte of requester i taken this cycle
//   out_data [7:0]       out  registered byte to serializer (COM when idle)
//   out_valid            out  registered; out_data is payload
//   grant_id [1:0]       out  registered index of current/last grant
//   busy                 out  registered; scheduler is in BURST
// ---------------------------------------------------------------------------
module ptos_sched
  import ptos_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int TRAIN_LEN = DEF_TRAIN_LEN
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [8*NREQ-1:0]   req_data,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  output logic [7:0]          out_data,
  output logic                out_valid,
  output logic [1:0]          grant_id,
  output logic                busy
);

  localparam int BC_W = $clog2(MAX_BURST + 1);
  localparam int TC_W = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;

  localparam logic [BC_W-1:0] BC_MAX  = BC_W'(MAX_BURST);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(MAX_BURST - 1);
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(TRAIN_LEN - 1);

  state_t            state;
  logic [TC_W-1:0]   train_cnt;
  logic [BC_W-1:0]   burst_cnt;
  logic [1:0]        rr_ptr;
  logic [NREQ-1:0]   grant_oh;

  logic [NREQ-1:0]   arb_gnt;
  logic [1:0]        arb_idx;
  logic              arb_any;

  logic              grant_valid;
  logic [7:0]        grant_byte;
  logic              accept;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // The granted requester's valid and byte. grant_oh mirrors grant_id as a
  // one-hot mask so the ready vector is a simple AND.
  assign grant_valid = |(req_valid & grant_oh);
  assign grant_byte  = req_data[{grant_id, 3'b000} +: 8];

  // A byte is taken only inside a burst that still has room and while the
  // link is enabled, so dropping enable withdraws ready in the same cycle.
  assign accept = (state == ST_BURST) && grant_valid &&
                  (burst_cnt < BC_MAX) && enable;

  // Ready goes only to the granted requester, and only when a byte moves.
  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready = grant_oh;
    end
  end

  // Scheduler FSM with registered outputs. Out_data defaults to COM every
  // cycle; only an accepted byte overrides it, which gives the one-cycle
  // output latency and COM on every non-accepting cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_TRAIN;
      train_cnt <= '0;
      burst_cnt <= '0;
      rr_ptr    <= '0;
      grant_id  <= '0;
      grant_oh  <= NREQ'(1);
      out_data  <= COM;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (!enable) begin
      state     <= ST_TRAIN;
      train_cnt <= '0;
      out_data  <= COM;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_data  <= COM;
      out_valid <= 1'b0;
      unique case (state)
        ST_TRAIN: begin
          if (train_cnt == TC_LAST) begin
            state     <= ST_IDLE;
            train_cnt <= '0;
          end else begin
            train_cnt <= train_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (arb_any) begin
            grant_id  <= arb_idx;
            grant_oh  <= arb_gnt;
            rr_ptr    <= wrap_inc(arb_idx, NREQ);
            burst_cnt <= '0;
            state     <= ST_BURST;
            busy      <= 1'b1;
          end
        end
        ST_BURST: begin
          if (accept) begin
            out_data  <= grant_byte;
            out_valid <= 1'b1;
            burst_cnt <= burst_cnt + 1'b1;
            if (burst_cnt == BC_LAST) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state     <= ST_TRAIN;
          train_cnt <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ptos_sched.sv
// ---------------------------------------------------------------------------
// tb_ptos_sched
// Directed bench for ptos_sched with default parameters (4 requesters,
// bursts of 4, 4 training cycles). A vector table covers training, a lone
// streaming requester and a requester dropping valid mid-burst; hand-written
// sequences cover round-robin rotation, enable loss and reset mid-burst.
// ---------------------------------------------------------------------------
module tb_ptos_sched;
  import ptos_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] req_data;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [1:0]  grant_id;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          rst;
    bit          en;
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  rdy;
    logic        ov;
    logic [7:0]  od;
    logic [1:0]  g;
    logic        bz;
  } vec_t;

  vec_t vecs[$];

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  ptos_sched dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .req_data  (req_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    enable    = 1'b1;
    req_valid = '0;
    req_data  = '0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic add_vec(input bit rst, input bit en, input logic [3:0] v,
                         input logic [31:0] d, input logic [3:0] rdy,
                         input logic ov, input logic [7:0] od,
                         input logic [1:0] g, input logic bz);
    vec_t r;
    r.rst = rst; r.en = en; r.v = v; r.d = d; r.rdy = rdy;
    r.ov = ov; r.od = od; r.g = g; r.bz = bz;
    vecs.push_back(r);
  endtask

  // One table row: drive inputs, check the combinational ready, clock once,
  // then check the registered outputs produced by that edge.
  task automatic applyStimulus(input int n, input vec_t r);
    if (r.rst) do_reset();
    enable    = r.en;
    req_valid = r.v;
    req_data  = r.d;
    #1;
    checkOutput($sformatf("vec%0d ready", n), 32'(req_ready), 32'(r.rdy));
    step();
    checkOutput($sformatf("vec%0d out_valid", n), 32'(out_valid), 32'(r.ov));
    checkOutput($sformatf("vec%0d out_data", n), 32'(out_data), 32'(r.od));
    checkOutput($sformatf("vec%0d grant_id", n), 32'(grant_id), 32'(r.g));
    checkOutput($sformatf("vec%0d busy", n), 32'(busy), 32'(r.bz));
  endtask

  initial begin
    int gseq[5];
    logic [7:0] rr_byte[4];

    // Lone requester 0: training with valid held, then EE CC BB 99 burst,
    // one COM gap, AA in a second burst.
    add_vec(1, 1, 4'b0001, 32'h0000_00EE, 4'b0000, 0, 8'hBC, 2'd0, 0);
    add_vec(0, 1, 4'b0001, 32'h0000_00EE, 4'b0000, 0, 8'hBC, 2'd0, 0);
    add_vec(0, 1, 4'b0001, 32'h0000_00EE, 4'b0000, 0, 8'hBC, 2'd0, 0);
    add_vec(0, 1, 4'b0001, 32'h0000_00EE, 4'b0000, 0, 8'hBC, 2'd0, 0);
    add_vec(0, 1, 4'b0001, 32'h0000_00EE, 4'b0000, 0, 8'hBC, 2'd0, 1);
    add_vec(0, 1, 4'b0001, 32'h0000_00EE, 4'b0001, 1, 8'hEE, 2'd0, 1);
    add_vec(0, 1, 4'b0001, 32'h0000_00CC, 4'b0001, 1, 8'hCC, 2'd0, 1);
    add_vec(0, 1, 4'b0001, 32'h0000_00BB, 4'b0001, 1, 8'hBB, 2'd0, 1);
    add_vec(0, 1, 4'b0001, 32'h0000_0099, 4'b0001, 1, 8'h99, 2'd0, 0);
    add_vec(0, 1, 4'b0001, 32'h0000_00AA, 4'b0000, 0, 8'hBC, 2'd0, 1);
    add_vec(0, 1, 4'b0001, 32'h0000_00AA, 4'b0001, 1, 8'hAA, 2'd0, 1);
    add_vec(0, 1, 4'b0000, 32'h0000_00AA, 4'b0000, 0, 8'hBC, 2'd0, 0);
    add_vec(0, 1, 4'b0000, 32'h0000_00AA, 4'b0000, 0, 8'hBC, 2'd0, 0);
    // Requester 2 drops valid after two DD bytes; requester 3 is next.
    add_vec(1, 1, 4'b1100, 32'h33DD_0000, 4'b0000, 0, 8'hBC, 2'd0, 0);
    add_vec(0, 1, 4'b1100, 32'h33DD_0000, 4'b0000, 0, 8'hBC, 2'd0, 0);
    add_vec(0, 1, 4'b1100, 32'h33DD_0000, 4'b0000, 0, 8'hBC, 2'd0, 0);
    add_vec(0, 1, 4'b1100, 32'h33DD_0000, 4'b0000, 0, 8'hBC, 2'd0, 0);
    add_vec(0, 1, 4'b1100, 32'h33DD_0000, 4'b0000, 0, 8'hBC, 2'd2, 1);
    add_vec(0, 1, 4'b1100, 32'h33DD_0000, 4'b0100, 1, 8'hDD, 2'd2, 1);
    add_vec(0, 1, 4'b1100, 32'h33DD_0000, 4'b0100, 1, 8'hDD, 2'd2, 1);
    add_vec(0, 1, 4'b1000, 32'h33DD_0000, 4'b0000, 0, 8'hBC, 2'd2, 0);
    add_vec(0, 1, 4'b1000, 32'h33DD_0000, 4'b0000, 0, 8'hBC, 2'd3, 1);
    add_vec(0, 1, 4'b1000, 32'h33DD_0000, 4'b1000, 1, 8'h33, 2'd3, 1);

    // Reset state, checked while reset is held with requests pending.
    reset     = 1'b1;
    enable    = 1'b1;
    req_valid = 4'hF;
    req_data  = 32'h4030_2010;
    #2 reset = 1'b0;
    #2;
    checkOutput("rst out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst out_data", 32'(out_data), 32'hBC);
    checkOutput("rst grant_id", 32'(grant_id), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst ready", 32'(req_ready), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(i, vecs[i]);
    end

    // Round robin with all four requesters streaming: grants 0,1,2,3,0.
    gseq[0] = 0; gseq[1] = 1; gseq[2] = 2; gseq[3] = 3; gseq[4] = 0;
    rr_byte[0] = 8'h10; rr_byte[1] = 8'h20; rr_byte[2] = 8'h30; rr_byte[3] = 8'h40;
    do_reset();
    req_valid = 4'hF;
    req_data  = 32'h4030_2010;
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("rr train busy", 32'(busy), 32'd0);
    end
    step();
    checkOutput("rr first grant", 32'(grant_id), 32'd0);
    checkOutput("rr first busy", 32'(busy), 32'd1);
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 4; k++) begin
        checkOutput($sformatf("rr b%0d k%0d ready", b, k), 32'(req_ready),
                    32'(1) << gseq[b]);
        step();
        checkOutput($sformatf("rr b%0d k%0d out_valid", b, k), 32'(out_valid), 32'd1);
        checkOutput($sformatf("rr b%0d k%0d out_data", b, k), 32'(out_data),
                    32'(rr_byte[gseq[b]]));
        checkOutput($sformatf("rr b%0d k%0d grant", b, k), 32'(grant_id), 32'(gseq[b]));
      end
      checkOutput($sformatf("rr b%0d end busy", b), 32'(busy), 32'd0);
      if (b < 4) begin
        checkOutput($sformatf("rr b%0d gap ready", b), 32'(req_ready), 32'd0);
        step();
        checkOutput($sformatf("rr b%0d gap valid", b), 32'(out_valid), 32'd0);
        checkOutput($sformatf("rr b%0d gap data", b), 32'(out_data), 32'hBC);
        checkOutput($sformatf("rr b%0d next grant", b), 32'(grant_id), 32'(gseq[b+1]));
      end
    end

    // Enable drops after the second byte of a burst from requester 1.
    do_reset();
    req_valid = 4'b0010;
    req_data  = 32'h0000_5100;
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("en train busy", 32'(busy), 32'd0);
    end
    step();
    checkOutput("en grant", 32'(grant_id), 32'd1);
    checkOutput("en ready b1", 32'(req_ready), 32'b0010);
    step();
    checkOutput("en byte1", 32'(out_data), 32'h51);
    req_data = 32'h0000_5200;
    step();
    checkOutput("en byte2 data", 32'(out_data), 32'h52);
    checkOutput("en byte2 valid", 32'(out_valid), 32'd1);
    req_data = 32'h0000_5300;
    enable   = 1'b0;
    #1;
    checkOutput("en low ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("en low valid", 32'(out_valid), 32'd0);
      checkOutput("en low busy", 32'(busy), 32'd0);
    end
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("en retrain ready", 32'(req_ready), 32'd0);
      step();
      checkOutput("en retrain busy", 32'(busy), 32'd0);
    end
    step();
    checkOutput("en regrant busy", 32'(busy), 32'd1);
    checkOutput("en regrant id", 32'(grant_id), 32'd1);
    step();
    checkOutput("en byte3", 32'(out_data), 32'h53);

    // Reset asserted mid-burst from requester 3.
    do_reset();
    req_valid = 4'b1000;
    req_data  = 32'h7700_0000;
    for (int i = 0; i < 5; i++) step();
    checkOutput("rm grant", 32'(grant_id), 32'd3);
    step();
    checkOutput("rm byte", 32'(out_data), 32'h77);
    #2 reset = 1'b0;
    #1;
    checkOutput("rm out_valid", 32'(out_valid), 32'd0);
    checkOutput("rm out_data", 32'(out_data), 32'hBC);
    checkOutput("rm grant_id", 32'(grant_id), 32'd0);
    checkOutput("rm busy", 32'(busy), 32'd0);
    checkOutput("rm ready", 32'(req_ready), 32'd0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("rm train valid", 32'(out_valid), 32'd0);
      checkOutput("rm train busy", 32'(busy), 32'd0);
    end
    step();
    checkOutput("rm regrant busy", 32'(busy), 32'd1);
    checkOutput("rm regrant id", 32'(grant_id), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ptos_sched.md
PTOS_SCHED -- requirements
Module: ptos_sched

Interface
REQ-001 Parameter NREQ, default 4: number of byte requesters sharing the serializer.
REQ-002 Parameter MAX_BURST, default 4: max bytes granted per burst.
REQ-003 Parameter TRAIN_LEN, default 4: COM idle cycles after reset release or enable rise.
REQ-004 Port clk  input  1  byte-rate clock; single clock domain, all logic on rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset.
REQ-006 Port enable  input  1  scheduler run enable; low forces training/idle.
REQ-007 Port req_data  input  8*NREQ  byte from requester i in bits [8i+7:8i].
REQ-008 Port req_valid  input  NREQ  requester i holds a valid byte.
REQ-009 Port req_ready  output  NREQ  requester i byte accepted when valid&ready at clk edge.
REQ-010 Port out_data  output  8  registered byte to parallel-to-serial input.
REQ-011 Port out_valid  output  1  registered; high = out_data is payload, low = serializer sends COM.
REQ-012 Port grant_id  output  2  registered index of current or last granted requester.
REQ-013 Port busy  output  1  high while in BURST.

Function
REQ-014 States SHALL be TRAIN, IDLE, BURST.
REQ-015 TRAIN: out_valid=0, out_data=8'hBC, req_ready=0; counter increments per cycle while enable=1; after TRAIN_LEN cycles -> IDLE.
REQ-016 IDLE: out_valid=0, out_data=8'hBC; if any req_valid, grant the first set bit searching round-robin from (last grant + 1) mod NREQ, load grant_id, clear burst count, -> BURST next cycle; else stay.
REQ-017 BURST: req_ready[grant_id] = req_valid[grant_id] && burst_cnt<MAX_BURST && enable, combinational; all other ready bits 0.
REQ-018 Each accepted byte SHALL appear on out_data with out_valid=1 exactly one cycle after acceptance; burst_cnt increments.
REQ-019 Cycles in BURST with no acceptance SHALL drive out_valid=0, out_data=8'hBC.
REQ-020 BURST -> IDLE on the cycle burst_cnt reaches MAX_BURST or req_valid[grant_id]=0; exactly one COM cycle separates consecutive bursts.
REQ-021 burst_cnt SHALL be ceil(log2(MAX_BURST+1)) bits and never exceed MAX_BURST.
REQ-022 Round-robin pointer wraps NREQ-1 -> 0; a lone requester is re-granted after the one-cycle gap.
REQ-023 enable=0 in any state: req_ready=0 same cycle, next state TRAIN with counter cleared; held there until enable=1, then full TRAIN_LEN again.
REQ-024 A byte accepted on the last enabled cycle SHALL still be presented one cycle later.
REQ-025 req_valid deasserted with req_ready high: no acceptance, no output byte.

Reset
REQ-026 reset=0 SHALL immediately force: state TRAIN, train counter 0, burst_cnt 0, out_data 8'hBC, out_valid 0, req_ready 0, grant_id 0, busy 0, RR pointer so requester 0 has highest priority.
REQ-027 Reset mid-burst SHALL drop the in-flight byte; no output byte after reset release until TRAIN completes.

Structure
REQ-028 Shared package ptos_pkg SHALL hold COM = 8'hBC, state encoding, and default parameter constants.
REQ-029 Round-robin selection SHALL live in sub-module rr_arbiter (req vector, pointer in; one-hot grant and index out, combinational).

Verification
REQ-030 Reset release, enable=1, no requests -> out_valid=0, out_data=8'hBC for 4 cycles TRAIN, then IDLE, no ready asserted.
REQ-031 Req0 streams 8'hEE,8'hCC,8'hBB,8'h99,8'hAA -> first 4 bytes out with 1-cycle latency, one COM gap, 8'hAA in a new burst.
REQ-032 Req0..3 all valid continuously with 8'h10,8'h20,8'h30,8'h40 -> grants 0,1,2,3,0, each burst 4 bytes, one COM gap between.
REQ-033 Req2 drops valid after 2 bytes (8'hDD,8'hDD) -> burst ends, next grant goes to req3 if valid.
REQ-034 enable low mid-burst after byte 2 -> ready drops same cycle, byte 2 still output, TRAIN 4 cycles after enable returns.
REQ-035 reset asserted mid-burst -> outputs at reset values immediately, grant_id=0, TRAIN restarts on release.
